// File: rtl/arb2_rr.sv
// arb2_rr: two-requester round-robin arbiter producing a registered,
// strictly one-hot grant pair for a downstream 2-to-1 encoder.
// The owner-done strobe is named `rel` because `release` is a reserved word.
module arb2_rr #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic rel,
  output logic gnt0,
  output logic gnt1,
  output logic busy,
  output logic timeout,
  output logic prio
);

  localparam int unsigned CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(HOLD_MAX);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          at_lim;
  logic          to_n;
  logic          prio_n;

  // Next-state, hold-count and priority decision for the coming edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    to_n    = 1'b0;
    prio_n  = prio;
    at_lim  = (cnt == LIMIT);

    case (state)
      IDLE: begin
        if (req0 && (!req1 || !prio)) state_n = G0;
        else if (req1)                state_n = G1;
      end
      G0: begin
        if (rel || !req0 || at_lim) begin
          state_n = req1 ? G1 : IDLE;
          to_n    = at_lim && !rel && req0;
        end
      end
      G1: begin
        if (rel || !req1 || at_lim) begin
          state_n = req0 ? G0 : IDLE;
          to_n    = at_lim && !rel && req1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Entry into a grant (from IDLE or by handoff) restarts the count at 1
    // and hands priority to the other requester.
    if (state_n == IDLE) begin
      cnt_n = '0;
    end else if (state_n != state) begin
      cnt_n  = ONE;
      prio_n = (state_n == G0);
    end else begin
      cnt_n = cnt + ONE;
    end
  end

  // State register; outputs are flopped from the next state so they are glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      prio    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gnt0    <= (state_n == G0);
      gnt1    <= (state_n == G1);
      busy    <= (state_n != IDLE);
      timeout <= to_n;
      prio    <= prio_n;
    end
  end

endmodule

// File: tb/tb_arb2_rr.sv
// tb_arb2_rr: directed + random stimulus shared by three arbiter instances
// (HOLD_MAX = 15, 3, 1); expected outputs come from a behavioural model
// and flow through a scoreboard queue.
module tb_arb2_rr;

  logic clk = 1'b0;
  logic rst, req0, req1, rel;

  logic g0_a, g1_a, b_a, t_a, p_a;
  logic g0_b, g1_b, b_b, t_b, p_b;
  logic g0_c, g1_c, b_c, t_c, p_c;

  logic [4:0] obs [3];
  assign obs[0] = {g0_a, g1_a, b_a, t_a, p_a};
  assign obs[1] = {g0_b, g1_b, b_b, t_b, p_b};
  assign obs[2] = {g0_c, g1_c, b_c, t_c, p_c};

  arb2_rr #(.HOLD_MAX(15)) dut_a (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .rel(rel),
    .gnt0(g0_a), .gnt1(g1_a), .busy(b_a), .timeout(t_a), .prio(p_a));
  arb2_rr #(.HOLD_MAX(3)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .rel(rel),
    .gnt0(g0_b), .gnt1(g1_b), .busy(b_b), .timeout(t_b), .prio(p_b));
  arb2_rr #(.HOLD_MAX(1)) dut_c (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .rel(rel),
    .gnt0(g0_c), .gnt1(g1_c), .busy(b_c), .timeout(t_c), .prio(p_c));

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: 0 = idle, 1 = owner 0, 2 = owner 1
  int unsigned hold [3] = '{15, 3, 1};
  int          mst  [3] = '{0, 0, 0};
  int          mcnt [3] = '{0, 0, 0};
  bit          mpri [3] = '{0, 0, 0};

  logic [4:0] sb [$];
  int         gnt1_cycles;

  function automatic logic [4:0] model_next(input int i, input logic r,
                                            input logic a, input logic b,
                                            input logic l);
    int nst;
    bit to;
    bit own_req, oth_req, lim;
    nst = mst[i];
    to  = 1'b0;
    if (r) begin
      mst[i] = 0; mcnt[i] = 0; mpri[i] = 1'b0;
      return 5'b00000;
    end
    if (mst[i] == 0) begin
      if (a && b) nst = mpri[i] ? 2 : 1;
      else if (a) nst = 1;
      else if (b) nst = 2;
    end else begin
      own_req = (mst[i] == 1) ? a : b;
      oth_req = (mst[i] == 1) ? b : a;
      lim     = (mcnt[i] == int'(hold[i]));
      if (l || !own_req || lim) begin
        nst = oth_req ? (3 - mst[i]) : 0;
        to  = lim && !l && own_req;
      end
    end
    if (nst == 0)            mcnt[i] = 0;
    else if (nst != mst[i]) begin
      mcnt[i] = 1;
      mpri[i] = (nst == 1);
    end else                 mcnt[i] = mcnt[i] + 1;
    mst[i] = nst;
    return {nst == 1, nst == 2, nst != 0, to, mpri[i]};
  endfunction

  task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: got %b required %b (gnt0 gnt1 busy timeout prio)", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic a,
                      input logic b, input logic l);
    logic [4:0] e;
    @(negedge clk);
    rst = r; req0 = a; req1 = b; rel = l;
    for (int i = 0; i < 3; i++) sb.push_back(model_next(i, r, a, b, l));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      check($sformatf("%s/h%0d", tag, hold[i]), obs[i], e);
      compared++;
      assert ((obs[i][4] & obs[i][3]) === 1'b0) else begin
        mismatched++;
        $error("FAIL onehot_%s/h%0d: got %b required 0", tag, hold[i], obs[i][4] & obs[i][3]);
      end
    end
    if (g1_a === 1'b1) gnt1_cycles++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rel = 1'b0;

    // Reset with both requests high, then first grant to requester 0
    step("rst0", 1, 1, 1, 0);
    step("rst1", 1, 1, 1, 0);
    step("first_gnt", 0, 1, 1, 0);
    compared++;
    assert ({g0_a, p_a} === 2'b11) else begin
      mismatched++;
      $error("FAIL first_gnt_direct: got %b required 11", {g0_a, p_a});
    end
    step("drop", 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0);

    // Single requester: req1 for three cycles, gnt1 for three cycles
    gnt1_cycles = 0;
    for (int k = 0; k < 3; k++) step("single", 0, 0, 1, 0);
    step("single_end", 0, 0, 0, 0);
    step("single_idle", 0, 0, 0, 0);
    compared++;
    assert (gnt1_cycles === 3) else begin
      mismatched++;
      $error("FAIL single_len: got %0d required 3", gnt1_cycles);
    end

    // Full contention, release every fourth cycle
    for (int k = 0; k < 16; k++) step("contend", 0, 1, 1, (k % 4) == 3);
    step("contend_end", 0, 0, 0, 0);

    // Hold limit: req0 held, req1 raised on the fifth cycle
    for (int k = 0; k < 12; k++) step("hold", 0, 1, k >= 4, 0);
    step("hold_end", 0, 0, 0, 0);

    // Reset during the second cycle of a grant to requester 1
    step("g1_a", 0, 0, 1, 0);
    step("g1_b", 0, 0, 1, 0);
    step("mid_rst", 1, 1, 1, 0);
    step("post_rst", 0, 1, 1, 0);
    compared++;
    assert ({g0_a, g1_a, p_a} === 3'b101) else begin
      mismatched++;
      $error("FAIL post_rst_direct: got %b required 101", {g0_a, g1_a, p_a});
    end

    // Release and req0 drop together while owner 0 with req1 pending
    step("sim_edge", 0, 0, 1, 1);
    compared++;
    assert ({g1_a, t_a} === 2'b10) else begin
      mismatched++;
      $error("FAIL sim_edge_direct: got %b required 10", {g1_a, t_a});
    end
    step("sim_drop", 0, 0, 0, 0);

    // Both held: HOLD_MAX=1 instance alternates with a timeout each cycle
    for (int k = 0; k < 8; k++) step("alt", 0, 1, 1, 0);
    step("alt_end", 0, 0, 0, 0);

    // Random traffic
    for (int k = 0; k < 300; k++)
      step("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/arb2_rr.md
# arb2_rr

Two-request round-robin arbiter that sits directly upstream of the 2-to-1 encoder. It turns raw, possibly overlapping level requests into a registered, strictly one-hot grant pair that drives the encoder's `in0`/`in1`, so the encoder's undefined "both high" case never occurs. Each grant is held until the owner releases it, drops its request, or exceeds a hold limit. Priority alternates between requesters for fairness.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive grant cycles for one owner. Legal range is 1..255.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0` input 1: level request from requester 0.
- `req1` input 1: level request from requester 1.
- `release` input 1: the current owner is done; ignored when no grant is active.
- `gnt0` output 1: registered grant to requester 0; drives encoder `in0`.
- `gnt1` output 1: registered grant to requester 1; drives encoder `in1`.
- `busy` output 1: registered; equals `gnt0 | gnt1`.
- `timeout` output 1: registered one-cycle pulse when a grant is forcibly ended by `HOLD_MAX`.
- `prio` output 1: registered; the requester favoured on the next contention (0 means `req0` wins).

## Operation
- Reset values: state IDLE; `gnt0`, `gnt1`, `busy`, `timeout` all 0; `prio` 0; hold counter 0.
- State machine states are IDLE, G0 and G1. `gnt0` is 1 only in G0, and `gnt1` is 1 only in G1. The grants are never simultaneously 1.
- From IDLE:
  - `req0` & !`req1` goes to G0.
  - !`req0` & `req1` goes to G1.
  - Both high: go to G0 if `prio`=0, else G1.
  - Neither high: stay in IDLE.
- In Gx, the grant ends at the next edge if any of these is true:
  - `release`=1,
  - `reqx`=0,
  - the hold counter equals `HOLD_MAX`.
- On grant end:
  - If the other request is high, move directly to Gy with no idle gap.
  - Otherwise go to IDLE.
  - A direct handoff starts the new grant's hold count at 1.
- Hold counter:
  - Width is $clog2(HOLD_MAX+1).
  - Loaded with 1 on entry to any Gx, incremented each further cycle in Gx, and cleared in IDLE.
  - Never wraps, because exit is forced at `HOLD_MAX`.
- `HOLD_MAX`=1 means every grant lasts exactly one cycle.
- `timeout` is 1 for exactly one cycle: the cycle after a grant ends solely because of the hold limit. If `release` or a request drop coincides with the limit, `timeout` stays 0.
- `prio` updates on every entry into Gx to favour the other requester (`prio` ← !x), and holds its value in IDLE.
- Simultaneous `release` and new requests in the same cycle: the release ends the current grant, and the next owner is chosen by the handoff rule.
- A requester that keeps `req` high after its own grant ends is re-granted only after the other requester is served, or from IDLE if the other is not requesting. There is no self-handoff from Gx directly back to Gx.

## Timing
- Request-to-grant latency: 1 clock. A `req` sampled high at edge n from IDLE gives a grant visible after edge n.
- Release-to-deassert latency: 1 clock. Handoff is also 1 clock: `gntx` falls and `gnty` rises on the same edge.
- Maximum continuous grant is `HOLD_MAX` cycles. Under full contention, grants alternate with zero dead cycles.
- Reset asserted mid-grant: at the next edge all outputs return to reset values, regardless of `req` or `release`.
- After `rst` deasserts, the first grant can appear one edge after a request is sampled.
- All outputs are glitch-free flops, with no combinational path from inputs to outputs.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with `req0`=`req1`=1 → `gnt0`=`gnt1`=0, `busy`=0, `prio`=0. Release `rst` → `gnt0`=1 one edge later, then `prio`=1.
- Single requester: pulse `req1`=1 for 3 cycles, then 0, with `release`=0 → `gnt1` high for 3 cycles starting one edge after the rise, then IDLE. `timeout` is never asserted.
- Contention with release: hold `req0`=`req1`=1, pulse `release` every 4th cycle → grants alternate G0,G1,G0,… Each grant lasts 4 cycles, the grants are never both 1, and there is no idle cycle between them.
- Hold limit: `HOLD_MAX`=3, `req0` held high, `req1` raised on cycle 5 → `gnt0` for 3 cycles, then `timeout`=1 for 1 cycle. Check whether `req1` was high at the limit: if so, hand off to `gnt1`; otherwise go to IDLE and re-grant `gnt0`.
- Reset mid-operation: assert `rst` in the second cycle of G1 → the next edge gives `gnt1`=0, `prio`=0, hold counter 0. After deassert with both requests high, `gnt0` wins.
- Simultaneous edge case: `release`=1 and a `req0` drop in the same cycle while in G0 with `req1`=1 → handoff to G1 and `timeout`=0. Also, `HOLD_MAX`=1 with both requests held → grants alternate every cycle and `timeout` pulses on each forced end.
